jtag_seq_ctrl: RTL and testbench
================================

# jtag_seq_ctrl

Host-side JTAG sequencer that drives TMS/TDI toward a target TAP controller and captures TDO. It accepts scan commands over a valid/ready interface and expands each into the exact cycle-by-cycle TMS/TDI sequence. It tracks the target TAP state with an internal mirror and returns captured TDO bits on a response channel. It is the front end that sequences the TAP for the JTAG-to-AXI bridge and for testbenches.

## Interface
- `MAX_LEN`, default 64: maximum scan length in bits.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of the command length field.
- `IDLE_GAP`, default 2: extra Run-Test/Idle cycles after each command; used only when the gap feature is compiled in.
- `tck` in 1: JTAG clock; all logic runs on its rising edge.
- `trst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: `jtag_seq_op_t` (RESET, IDLE, SCAN_IR, SCAN_DR).
- `cmd_len` in LEN_W: shift bits for SCAN ops; idle cycles for IDLE.
- `cmd_data` in MAX_LEN: TDI bits, LSB shifted first.
- `rsp_valid` out 1: response available; held until taken.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data` out MAX_LEN: captured TDO, bit i = i-th shifted bit; unused bits are 0.
- `rsp_err` out 1: command rejected; no TAP activity occurred.
- `tms` out 1: registered TMS to the target.
- `tdi` out 1: registered TDI to the target.
- `tdo` in 1: TDO from the target.
- `tap_state` out `tap_ctrl_fsm_t`: mirrored target TAP state.
- `busy` out 1: a sequence is in progress.

## Operation
- `tms` and `tdi` are registered. A value set at rising edge k is sampled by the target at edge k+1.
- The mirror FSM is clocked by `tck` and fed from the `tms` register, so it matches the target exactly.
- **Controller states:** INIT, IDLE, RST, RUN, SEL_DR, SEL_IR, CAP, SHIFT, EXIT1, UPDATE, RSP.
- **INIT (after reset release):**
  - Drive `tms` = 1 for 5 cycles, then 0 for 1 cycle.
  - The mirror then reaches RUN_TEST_IDLE and the controller enters IDLE.
- **IDLE:** `cmd_ready` = 1 only in this state. Every command starts and ends with the TAP in RUN_TEST_IDLE.
- **RESET:** TMS sequence 1,1,1,1,1,0.
- **IDLE op:** drive `tms` = 0 for `cmd_len` cycles. With `cmd_len` = 0, the response is issued immediately with no TAP cycles.
- **SCAN_DR TMS sequence:** 1, 0, 0, then n shift cycles, then 1, 0.
  - Shift cycles carry TMS = 0, except the last shift cycle, which carries TMS = 1.
- **SCAN_IR TMS sequence:** 1, 1, 0, 0, then n shift cycles, then 1, 0.
- **TDI:** during shift cycle i, `tdi` = `cmd_data[i]`. Outside shift cycles, `tdi` = 0.
- **TDO capture:** `tdo` is sampled at every edge where the mirror state, before the edge, is SHIFT_DR or SHIFT_IR. The i-th such sample is stored in `rsp_data[i]`.
- **Rejected commands:** a SCAN with `cmd_len` = 0 or `cmd_len` > `MAX_LEN` gets `rsp_err` = 1 and `rsp_data` = 0, with no TAP cycles. IDLE with `cmd_len` > `MAX_LEN` is legal.
- **Responses:**
  - Every accepted command produces exactly one response; RESET and IDLE return data 0.
  - `cmd_ready` stays 0 while `rsp_valid` = 1.
  - `tms` is held at 0 (TAP parked in RUN_TEST_IDLE) while waiting for `rsp_ready`.
- **Reset values:** `tms` = 1, `tdi` = 0, `cmd_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `busy` = 1, `tap_state` = TEST_LOGIC_RESET.
- **Reset mid-command:** the in-flight command is dropped and no response is issued. INIT then reruns.

## Timing
- Command accepted at edge k. The first driven value is registered at edge k.
- `rsp_valid` rises at the following edges (gap feature compiled out):
  - SCAN_DR: edge k+n+5.
  - SCAN_IR: edge k+n+6.
  - RESET: edge k+6.
  - IDLE: edge k+len, or k+1 when len = 0.
  - Rejected command: edge k+1.
- The response handshake at edge j returns to IDLE at that edge. `cmd_ready` = 1 at edge j, so back-to-back accept is possible at j+1.
- After `trst` is released, `cmd_ready` first rises at the 6th rising edge.

## Configuration
- **`JTAG_SEQ_IDLE_GAP_EN` defined:** after every RESET or SCAN, the controller drives `tms` = 0 for `IDLE_GAP` extra cycles before `rsp_valid` rises. All latencies above grow by `IDLE_GAP`.
- **Undefined:** no gap. The `IDLE_GAP` parameter is ignored.

## Structure
- `jtag_pkg` gains `jtag_seq_op_t` (OP_RESET = 0, OP_IDLE = 1, OP_SCAN_IR = 2, OP_SCAN_DR = 3) and the controller state enum. It reuses the existing `tap_ctrl_fsm_t`.
- One sub-module: a `tap_ctrl_fsm` instance as the mirror, with `trstn` = `~trst`, `tms` from the `tms` register, and `tap_state` brought out to the port.

## Test plan
- **Reset release:** TMS stream is 1,1,1,1,1,0. `tap_state` = RUN_TEST_IDLE, and `cmd_ready` = 1 at edge 6.
- **SCAN_IR, len 4, data 0x5, TDO model returns 0b1001:** TDI stream LSB-first is 1,0,1,0. `rsp_data` = 0x9, `rsp_valid` at k+10, TAP ends in RUN_TEST_IDLE.
- **SCAN_DR, len 32, data 0xDEADBEEF, loopback TDO = delayed TDI:** `rsp_data` = 0xDEADBEEF, `rsp_valid` at k+37.
- **Invalid lengths:** SCAN_DR with len 0, and with len `MAX_LEN`+1 → `rsp_err` = 1 at k+1, `tms` constant 0.
- **Backpressure:** `rsp_ready` held low for 10 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready` = 0, TAP stays in RUN_TEST_IDLE.
- **Mid-scan reset:** assert `trst` during a SHIFT_DR cycle → all outputs take reset values, no response is issued, INIT reruns and `tap_state` returns to RUN_TEST_IDLE.

Source files
------------

// File: rtl/jtag_pkg.sv
// JTAG shared types: TAP state encoding, sequencer ops and
// sequencer controller states.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_ctrl_fsm_t;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_SCAN_IR = 2'd2,
    OP_SCAN_DR = 2'd3
  } jtag_seq_op_t;

  typedef enum logic [3:0] {
    SEQ_INIT,
    SEQ_IDLE,
    SEQ_RST,
    SEQ_RUN,
    SEQ_SEL_DR,
    SEQ_SEL_IR,
    SEQ_CAP,
    SEQ_SHIFT,
    SEQ_EXIT1,
    SEQ_UPDATE,
    SEQ_RSP
  } jtag_seq_state_t;

  function automatic logic is_shift(tap_ctrl_fsm_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/jtag_seq_ctrl_if.sv
// Command/response channel between a host and jtag_seq_ctrl.
// master = host side, slave = sequencer side.
interface jtag_seq_ctrl_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  jtag_pkg::jtag_seq_op_t cmd_op;
  logic [LEN_W-1:0]      cmd_len;
  logic [MAX_LEN-1:0]    cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [MAX_LEN-1:0]    rsp_data;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len,
    output cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len,
    input  cmd_data, rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_data, rsp_err
  );
endinterface

// File: rtl/tap_ctrl_fsm.sv
// IEEE 1149.1 TAP controller state machine; used as a mirror
// of the target TAP, advanced by the registered TMS.
module tap_ctrl_fsm
  import jtag_pkg::*;
(
  input  logic          tck,
  input  logic          trstn,
  input  logic          tms,
  output tap_ctrl_fsm_t tap_state
);

  tap_ctrl_fsm_t st_d;

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) tap_state <= TEST_LOGIC_RESET;
    else        tap_state <= st_d;
  end

  always_comb begin
    st_d = tap_state;
    unique case (tap_state)
      TEST_LOGIC_RESET:
        st_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:
        st_d = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:
        st_d = tms ? SELECT_IR_SCAN : CAPTURE_DR;
      CAPTURE_DR:
        st_d = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:
        st_d = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:
        st_d = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:
        st_d = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:
        st_d = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:
        st_d = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_IR_SCAN:
        st_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:
        st_d = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:
        st_d = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:
        st_d = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:
        st_d = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:
        st_d = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:
        st_d = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      default:
        st_d = TEST_LOGIC_RESET;
    endcase
  end

endmodule

// File: rtl/jtag_seq_ctrl.sv
// Host-side JTAG sequencer: expands commands into TMS/TDI streams.
// Optional JTAG_SEQ_IDLE_GAP_EN adds IDLE_GAP idle cycles per command.
module jtag_seq_ctrl
  import jtag_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = $clog2(MAX_LEN+1),
  parameter int IDLE_GAP = 2
) (
  input  logic           tck,
  input  logic           trst,
  jtag_seq_ctrl_if.slave bus,
  output logic           tms,
  output logic           tdi,
  input  logic           tdo,
  output tap_ctrl_fsm_t  tap_state,
  output logic           busy
);

`ifdef JTAG_SEQ_IDLE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int GAP = GAP_EN ? IDLE_GAP : 0;
  localparam int CW  = (LEN_W > 8 ? LEN_W : 8) + 1;

  jtag_seq_state_t    st_q, st_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] dat_q, dat_d;
  logic               ir_q, ir_d;
  logic               err_q, err_d;
  logic               tms_d, tdi_d;
  logic [MAX_LEN-1:0] cap_q;
  logic [LEN_W-1:0]   cap_idx;

  logic is_scan, is_rst, bad_len, scan_ok, acc;
  logic [CW-1:0] idle_run;

  assign is_scan = (bus.cmd_op == OP_SCAN_IR) ||
                   (bus.cmd_op == OP_SCAN_DR);
  assign is_rst  = (bus.cmd_op == OP_RESET);
  assign bad_len = is_scan &&
                   ((bus.cmd_len == '0) ||
                    (bus.cmd_len > LEN_W'(MAX_LEN)));
  assign scan_ok = is_scan && !bad_len;
  assign idle_run = (bus.cmd_len == '0) ? CW'(1)
                                        : CW'(bus.cmd_len);
  assign acc = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready = (st_q == SEQ_IDLE);
  assign bus.rsp_valid = (st_q == SEQ_RSP);
  assign bus.rsp_data  = cap_q;
  assign bus.rsp_err   = err_q;
  assign busy = (st_q != SEQ_IDLE) && (st_q != SEQ_RSP);

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      st_q  <= SEQ_INIT;
      cnt_q <= '0;
      len_q <= '0;
      dat_q <= '0;
      ir_q  <= 1'b0;
      err_q <= 1'b0;
      tms   <= 1'b1;
      tdi   <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      dat_q <= dat_d;
      ir_q  <= ir_d;
      err_q <= err_d;
      tms   <= tms_d;
      tdi   <= tdi_d;
    end
  end

  // Each state names the TAP state in which the value it
  // registers will be sampled by the target.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    len_d = len_q;
    dat_d = dat_q;
    ir_d  = ir_q;
    err_d = err_q;
    tms_d = 1'b0;
    tdi_d = 1'b0;
    unique case (st_q)
      SEQ_INIT: begin
        tms_d = (cnt_q < CW'(4));
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(5)) begin
          st_d  = SEQ_IDLE;
          cnt_d = '0;
        end
      end
      SEQ_IDLE: begin
        if (bus.cmd_valid) begin
          err_d = 1'b0;
          len_d = bus.cmd_len;
          dat_d = bus.cmd_data;
          ir_d  = (bus.cmd_op == OP_SCAN_IR);
          st_d  = SEQ_RUN;
          cnt_d = CW'(1);
          unique case (1'b1)
            bad_len: err_d = 1'b1;
            scan_ok: begin
              tms_d = 1'b1;
              st_d  = SEQ_SEL_DR;
              cnt_d = '0;
            end
            is_rst: begin
              tms_d = 1'b1;
              st_d  = SEQ_RST;
              cnt_d = '0;
            end
            default: cnt_d = idle_run;
          endcase
        end
      end
      SEQ_RST: begin
        tms_d = (cnt_q < CW'(4));
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(4)) begin
          st_d  = SEQ_RUN;
          cnt_d = CW'(GAP + 1);
        end
      end
      SEQ_RUN: begin
        if (cnt_q <= CW'(1)) st_d = SEQ_RSP;
        else cnt_d = cnt_q - CW'(1);
      end
      SEQ_SEL_DR: begin
        tms_d = ir_q;
        st_d  = ir_q ? SEQ_SEL_IR : SEQ_CAP;
      end
      SEQ_SEL_IR: st_d = SEQ_CAP;
      SEQ_CAP: begin
        st_d  = SEQ_SHIFT;
        cnt_d = '0;
      end
      SEQ_SHIFT: begin
        tdi_d = dat_q[0];
        dat_d = dat_q >> 1;
        tms_d = (cnt_q == CW'(len_q) - CW'(1));
        cnt_d = cnt_q + CW'(1);
        if (tms_d) st_d = SEQ_EXIT1;
      end
      SEQ_EXIT1: begin
        tms_d = 1'b1;
        st_d  = SEQ_UPDATE;
      end
      SEQ_UPDATE: begin
        st_d  = SEQ_RUN;
        cnt_d = CW'(GAP + 1);
      end
      SEQ_RSP: begin
        if (bus.rsp_ready) st_d = SEQ_IDLE;
      end
      default: st_d = SEQ_INIT;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      cap_q   <= '0;
      cap_idx <= '0;
    end else if (acc) begin
      cap_q   <= '0;
      cap_idx <= '0;
    end else if (is_shift(tap_state)) begin
      cap_q   <= cap_q |
                 ({{(MAX_LEN-1){1'b0}}, tdo} << cap_idx);
      cap_idx <= cap_idx + LEN_W'(1);
    end
  end

  tap_ctrl_fsm u_mirror (
    .tck       (tck),
    .trstn     (~trst),
    .tms       (tms),
    .tap_state (tap_state)
  );

endmodule

// File: tb/tb_jtag_seq_ctrl.sv
// Self-checking bench for jtag_seq_ctrl: directed and random
// commands against a stream-level model of the sequencer.
module tb_jtag_seq_ctrl;
  import jtag_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
`ifdef JTAG_SEQ_IDLE_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif

  logic tck = 1'b0;
  logic trst = 1'b1;
  logic tms, tdi, tdo, busy;
  logic tdo_bit = 1'b0;
  bit   tdo_loop = 1'b0;
  tap_ctrl_fsm_t tap_state;

  int vectors = 0;
  int miscompares = 0;

  jtag_seq_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_seq_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck       (tck),
    .trst      (trst),
    .bus       (bus),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tap_state (tap_state),
    .busy      (busy)
  );

  assign tdo = tdo_loop ? tdi : tdo_bit;

  always #5 tck = ~tck;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check_reset_vals(input string tag);
    vectors++;
    if ({tms, tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy}
        !== 6'b100001 || bus.rsp_data !== '0 ||
        tap_state !== TEST_LOGIC_RESET) begin
      miscompares++;
      $display("FAIL %s: tms%b tdi%b rdy%b vld%b err%b busy%b d=%h tap=%0d, want 1 0 0 0 0 1 0 tap=0",
               tag, tms, tdi, bus.cmd_ready, bus.rsp_valid,
               bus.rsp_err, busy, bus.rsp_data, tap_state);
    end
  endtask

  // Called #1 after the edge at which trst was released.
  task automatic init_seq(input string tag);
    bit exp_tms[6] = '{1, 1, 1, 1, 1, 0};
    for (int e = 0; e < 6; e++) begin
      vectors++;
      if (tms !== exp_tms[e] || bus.cmd_ready !== 1'b0 ||
          bus.rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_tms%0d: tms=%b rdy=%b vld=%b, want tms=%b rdy=0 vld=0",
                 tag, e, tms, bus.cmd_ready, bus.rsp_valid, exp_tms[e]);
      end
      @(posedge tck); #1;
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1 || tap_state !== RUN_TEST_IDLE ||
        busy !== 1'b0 || tms !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready: rdy=%b tap=%0d busy=%b tms=%b, want 1 tap=1 0 0",
               tag, bus.cmd_ready, tap_state, busy, tms);
    end
  endtask

  task automatic do_cmd(input jtag_seq_op_t op, input int len,
                        input logic [MAX_LEN-1:0] data,
                        input logic [MAX_LEN-1:0] pat,
                        input bit loop, input int hold,
                        input string tag);
    logic [1:0] eq[$];
    logic [MAX_LEN-1:0] edata;
    bit scan, eerr;
    int pre, n;
    scan = (op == OP_SCAN_IR) || (op == OP_SCAN_DR);
    eerr = scan && (len == 0 || len > MAX_LEN);
    pre  = (op == OP_SCAN_IR) ? 4 : 3;
    n    = (scan && !eerr) ? len : 0;
    edata = '0;
    if (eerr) begin
      eq.push_back(2'b00);
    end else if (scan) begin
      for (int i = 0; i < pre; i++)
        eq.push_back({(op == OP_SCAN_IR) ? (i < 2) : (i == 0), 1'b0});
      for (int i = 0; i < n; i++) begin
        eq.push_back({i == n - 1, data[i]});
        edata[i] = loop ? data[i] : pat[i];
      end
      eq.push_back(2'b10);
      eq.push_back(2'b00);
      repeat (G) eq.push_back(2'b00);
    end else if (op == OP_RESET) begin
      repeat (5) eq.push_back(2'b10);
      eq.push_back(2'b00);
      repeat (G) eq.push_back(2'b00);
    end else begin
      repeat ((len == 0) ? 1 : len) eq.push_back(2'b00);
    end

    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_start: cmd_ready=%b, want 1", tag, bus.cmd_ready);
    end
    tdo_loop = loop;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    @(posedge tck); #1;
    bus.cmd_valid = 1'b0;

    for (int c = 0; c < eq.size(); c++) begin
      vectors++;
      if ({tms, tdi, bus.rsp_valid} !== {eq[c], 1'b0}) begin
        miscompares++;
        $display("FAIL %s_cyc%0d: tms=%b tdi=%b vld=%b, want %b %b 0",
                 tag, c, tms, tdi, bus.rsp_valid, eq[c][1], eq[c][0]);
      end
      if (n > 0 && c == pre) begin
        vectors++;
        if (tap_state !== ((op == OP_SCAN_IR) ? SHIFT_IR : SHIFT_DR)) begin
          miscompares++;
          $display("FAIL %s_shift: tap=%0d, want shift state", tag, tap_state);
        end
      end
      if (c >= pre && c < pre + n) tdo_bit = pat[c - pre];
      else tdo_bit = 1'($urandom);
      @(posedge tck); #1;
    end

    vectors++;
    if ({bus.rsp_valid, bus.rsp_err} !== {1'b1, eerr} ||
        bus.rsp_data !== edata) begin
      miscompares++;
      $display("FAIL %s_rsp: vld=%b err=%b data=%h, want 1 %b %h",
               tag, bus.rsp_valid, bus.rsp_err, bus.rsp_data, eerr, edata);
    end
    vectors++;
    if (tap_state !== RUN_TEST_IDLE || tms !== 1'b0 ||
        bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_park: tap=%0d tms=%b rdy=%b, want tap=1 0 0",
               tag, tap_state, tms, bus.cmd_ready);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge tck); #1;
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== edata ||
          bus.cmd_ready !== 1'b0 || tms !== 1'b0 ||
          tap_state !== RUN_TEST_IDLE) begin
        miscompares++;
        $display("FAIL %s_hold%0d: vld=%b data=%h rdy=%b tms=%b tap=%0d, want 1 %h 0 0 1",
                 tag, h, bus.rsp_valid, bus.rsp_data, bus.cmd_ready,
                 tms, tap_state, edata);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge tck); #1;
    bus.rsp_ready = 1'b0;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: rdy=%b vld=%b, want 1 0",
               tag, bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    trst = 1'b1;
    repeat (3) @(posedge tck);
    #1;
    check_reset_vals("reset");
    trst = 1'b0;
    init_seq("init");
  endtask

  task automatic test_scan_ir();
    do_cmd(OP_SCAN_IR, 4, 64'h5, 64'h9, 1'b0, 0, "scan_ir");
  endtask

  task automatic test_scan_dr_loop();
    do_cmd(OP_SCAN_DR, 32, 64'hDEADBEEF, 64'h0, 1'b1, 0, "dr_loop");
    do_cmd(OP_SCAN_DR, MAX_LEN, {$urandom, $urandom}, 64'h0,
           1'b1, 1, "dr_full");
  endtask

  task automatic test_invalid_len();
    do_cmd(OP_SCAN_DR, 0, 64'hFFFF, 64'hFFFF, 1'b0, 0, "bad_len0");
    do_cmd(OP_SCAN_DR, MAX_LEN + 1, 64'hFFFF, 64'hFFFF,
           1'b0, 0, "bad_len_max");
  endtask

  task automatic test_ops();
    do_cmd(OP_RESET, 0, 64'h0, 64'h0, 1'b0, 0, "op_reset");
    do_cmd(OP_IDLE, 0, 64'h0, 64'h0, 1'b0, 0, "idle0");
    do_cmd(OP_IDLE, 5, 64'h0, 64'h0, 1'b0, 0, "idle5");
    do_cmd(OP_IDLE, 100, 64'h0, 64'h0, 1'b0, 0, "idle100");
  endtask

  task automatic test_backpressure();
    do_cmd(OP_SCAN_DR, 8, 64'hA5, 64'h3C, 1'b0, 10, "bp");
  endtask

  task automatic test_back_to_back();
    do_cmd(OP_SCAN_IR, 5, 64'h1B, 64'h12, 1'b0, 0, "b2b_a");
    do_cmd(OP_SCAN_DR, 3, 64'h6, 64'h5, 1'b0, 0, "b2b_b");
    do_cmd(OP_IDLE, 1, 64'h0, 64'h0, 1'b0, 0, "b2b_c");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      jtag_seq_op_t op;
      int len;
      op = jtag_seq_op_t'($urandom_range(0, 3));
      if (op == OP_IDLE) len = $urandom_range(0, 12);
      else if ($urandom_range(0, 9) == 0)
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 127);
      else len = $urandom_range(1, MAX_LEN);
      do_cmd(op, len, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", t));
    end
  endtask

  task automatic test_mid_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SCAN_DR;
    bus.cmd_len   = LEN_W'(20);
    bus.cmd_data  = {$urandom, $urandom};
    @(posedge tck); #1;
    bus.cmd_valid = 1'b0;
    repeat (8) begin
      @(posedge tck); #1;
    end
    vectors++;
    if (tap_state !== SHIFT_DR) begin
      miscompares++;
      $display("FAIL mid_pre: tap=%0d, want %0d", tap_state, SHIFT_DR);
    end
    trst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(posedge tck); #1;
    trst = 1'b0;
    init_seq("mid_init");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_RESET;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_scan_ir();
    test_scan_dr_loop();
    test_invalid_len();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_scan_ir();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
